// File: rtl/regfile.sv
// Two-read/one-write register file with same-cycle write-to-read bypass; r0 reads as zero.
// Optional write trace outputs (commit count, last address/data) enabled by REGFILE_WRITE_TRACE_EN.
module regfile #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
`ifdef REGFILE_WRITE_TRACE_EN
   ,
   output logic [31:0]       wr_count,
   output logic [ADDR_W-1:0] last_waddr,
   output logic [DATA_W-1:0] last_wdata
`endif
);

   localparam int unsigned CNT_W = 32;

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic              wr_commit;

   // Writes to r0 are dropped; reset takes priority over any write.
   assign wr_commit = we && (waddr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_commit) begin
         rf_q[waddr] <= wdata;
      end
   end

   // Read port 1: reset, r0 and disabled port all yield zero; a same-cycle write bypasses the array.
   always_comb begin
      rdata1 = '0;
      if (!rst && (raddr1 != '0) && re1) begin
         rdata1 = (we && (waddr == raddr1)) ? wdata : rf_q[raddr1];
      end
   end

   // Read port 2: identical rules to port 1.
   always_comb begin
      rdata2 = '0;
      if (!rst && (raddr2 != '0) && re2) begin
         rdata2 = (we && (waddr == raddr2)) ? wdata : rf_q[raddr2];
      end
   end

`ifdef REGFILE_WRITE_TRACE_EN
   logic [CNT_W-1:0]  wr_count_q,   wr_count_d;
   logic [ADDR_W-1:0] last_waddr_q, last_waddr_d;
   logic [DATA_W-1:0] last_wdata_q, last_wdata_d;

   always_comb begin
      wr_count_d   = wr_count_q;
      last_waddr_d = last_waddr_q;
      last_wdata_d = last_wdata_q;
      if (wr_commit) begin
         wr_count_d   = wr_count_q + CNT_W'(1);
         last_waddr_d = waddr;
         last_wdata_d = wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count_q   <= '0;
         last_waddr_q <= '0;
         last_wdata_q <= '0;
      end else begin
         wr_count_q   <= wr_count_d;
         last_waddr_q <= last_waddr_d;
         last_wdata_q <= last_wdata_d;
      end
   end

   assign wr_count   = wr_count_q;
   assign last_waddr = last_waddr_q;
   assign last_wdata = last_wdata_q;
`endif

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file at the far end of the write-back stage.
- Consumes the write-back triple (register address, write-enable, data) and commits it to architectural state on the rising clock edge.
- Supplies two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- we  input  1  write enable from write-back.
- waddr  input  ADDR_W  write register address.
- wdata  input  DATA_W  write data.
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2 (combinational).

Behaviour:
- Reset:
  - One clock is used. Reset is synchronous and active-high: when rst=1 at a rising clk edge, all NUM_REGS registers are cleared to 0.
  - Any write presented in that cycle is discarded.
  - While rst=1, rdata1 and rdata2 are forced to 0 combinationally.
- Write:
  - At a rising edge with rst=0, we=1 and waddr!=0, reg[waddr] <= wdata.
  - A write to address 0 is silently dropped; reg[0] is always 0.
  - Write latency: 1 cycle to architectural state.
- Read (identical rules for port n=1,2, evaluated in priority order):
  - rst=1 -> 0.
  - else raddrn==0 -> 0, even if a write to 0 is pending.
  - else ren=0 -> 0.
  - else we=1 and waddr==raddrn -> wdata (bypass: a same-cycle write is visible to decode with zero latency).
  - else reg[raddrn].
- Simultaneous events:
  - Both ports may read the same address; both return the same value.
  - Both ports may hit the bypass in the same cycle.
- X safety: with we=0, waddr and wdata are don't-care and must not affect any output.
- No stalls or handshakes. Write-back never back-pressures; the block accepts one write per cycle unconditionally.

Optional Feature:
- Macro: REGFILE_WRITE_TRACE_EN.
- When defined, adds three outputs:
  - wr_count (32 bits): counts committed writes, i.e. we=1, waddr!=0, rst=0. Wraps modulo 2**32. Cleared by rst.
  - last_waddr (ADDR_W bits): address of the most recent committed write. Reset 0.
  - last_wdata (DATA_W bits): data of the most recent committed write. Reset 0.
  - All three are registered and update on the same edge as the register write.
  - Writes to address 0 do not update them.
- When undefined: these ports and their logic do not exist, and the port list is exactly as above.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, assert rst for 1 cycle, deassert, read raddr1=5 with re1=1 -> rdata1=0. During rst=1, both rdata outputs are 0 regardless of inputs.
- Basic write/read: write 0x12345678 to r7, next cycle we=0, re1=1, raddr1=7 -> rdata1=0x12345678. With re1=0 -> rdata1=0.
- Bypass: in the same cycle set we=1, waddr=9, wdata=0xA5A5A5A5, re1=re2=1, raddr1=raddr2=9 -> both rdata=0xA5A5A5A5 in that cycle. Next cycle with we=0 -> still 0xA5A5A5A5.
- Register zero: we=1, waddr=0, wdata=0xFFFFFFFF, and raddr1=0 in the same and following cycles -> rdata1=0 in both.
- Reset priority: rst=1 together with we=1, waddr=3, wdata=0x55 -> after rst drops, r3 reads 0.
- Trace (macro defined): 3 writes to r1, r2, r0 then rst=0 idle -> wr_count=2, last_waddr=2, last_wdata equals the r2 data. Preload wr_count path to 0xFFFFFFFF via 2**32-1 writes (or force) and perform one more write -> wr_count=0.
